// File: rtl/rv_pkg.sv
// Shared RV32I core constants: datapath sizing, named register indices
// and ALU operation encodings used by the decoder, ALU and register file.
package rv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = 5;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_RA   = 1;
  localparam int unsigned REG_SP   = 2;
  localparam int unsigned REG_GP   = 3;
  localparam int unsigned REG_TP   = 4;
  localparam int unsigned REG_T0   = 5;
  localparam int unsigned REG_T1   = 6;
  localparam int unsigned REG_T2   = 7;
  localparam int unsigned REG_S0   = 8;
  localparam int unsigned REG_S1   = 9;
  localparam int unsigned REG_A0   = 10;
  localparam int unsigned REG_A1   = 11;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_e;

  // Reference ALU behaviour shared by the ALU and anything that needs to
  // predict its result from register operands.
  function automatic logic [XLEN-1:0] alu_eval(input alu_op_e op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    unique case (op)
      ALU_ADD: alu_eval = a + b;
      ALU_SUB: alu_eval = a - b;
      ALU_AND: alu_eval = a & b;
      ALU_OR:  alu_eval = a | b;
      ALU_SLT: alu_eval = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      default: alu_eval = '0;
    endcase
  endfunction

endpackage

// File: rtl/reg_file_rport.sv
// One combinational register-file read port: x0 reads as zero, and an
// optional same-cycle forward of the in-flight write data.
module reg_file_rport
  import rv_pkg::*;
#(
  parameter int unsigned XLEN   = rv_pkg::XLEN,
  parameter int unsigned NREGS  = rv_pkg::NREGS,
  parameter int unsigned AW     = rv_pkg::AW,
  parameter bit          BYPASS = 1'b0
) (
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] regs [NREGS],
  input  logic            byp_en,
  input  logic [AW-1:0]   byp_addr,
  input  logic [XLEN-1:0] byp_data,
  output logic [XLEN-1:0] data
);

  // NOTE: every path assigns data after the default, so no latch is inferred.
  always_comb begin
    data = '0;
    if (addr != AW'(REG_ZERO)) begin
      if (BYPASS && byp_en && (byp_addr == addr)) data = byp_data;
      else                                         data = regs[addr];
    end
  end

endmodule

// File: rtl/reg_file.sv
// RV32I integer register file: two read ports and a debug port, one
// synchronous write port, hardwired x0 and a committed-write counter.
module reg_file
  import rv_pkg::*;
#(
  parameter int unsigned XLEN        = rv_pkg::XLEN,
  parameter int unsigned NREGS       = rv_pkg::NREGS,
  parameter int unsigned AW          = rv_pkg::AW,
  parameter bit          BYPASS      = 1'b0,
  parameter bit          RESET_CLEAR = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  input  logic [AW-1:0]   A3,
  input  logic [XLEN-1:0] WD3,
  input  logic            WE3,
  input  logic [AW-1:0]   DA,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  output logic [XLEN-1:0] DRD,
  output logic [31:0]     WCNT
);

  if ((NREGS < 2) || ((NREGS & (NREGS - 1)) != 0) || (AW != $clog2(NREGS))) begin : g_bad_cfg
    $error("reg_file: NREGS must be a power of two >= 2 and AW must equal log2(NREGS)");
  end

  logic [XLEN-1:0] regs_q [1:NREGS-1];
  logic [XLEN-1:0] regs_view [NREGS];
  logic [31:0]     wcnt_q;
  logic            wr_en;

  assign wr_en = WE3 && (A3 != AW'(REG_ZERO));

  // x0 has no flop; the read ports see a constant zero in its slot.
  always_comb begin
    regs_view[0] = '0;
    for (int i = 1; i < NREGS; i++) regs_view[i] = regs_q[i];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values. The storage array is reset explicitly because
  // cleared-on-reset is architecturally visible, not just an init nicety.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q <= '0;
      if (RESET_CLEAR) begin
        for (int i = 1; i < NREGS; i++) regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[A3] <= WD3;
      wcnt_q     <= wcnt_q + 32'd1;
    end
  end

  assign WCNT = wcnt_q;

  reg_file_rport #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .BYPASS(BYPASS)) u_rport1 (
    .addr     (A1),
    .regs     (regs_view),
    .byp_en   (wr_en),
    .byp_addr (A3),
    .byp_data (WD3),
    .data     (RD1)
  );

  reg_file_rport #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .BYPASS(BYPASS)) u_rport2 (
    .addr     (A2),
    .regs     (regs_view),
    .byp_en   (wr_en),
    .byp_addr (A3),
    .byp_data (WD3),
    .data     (RD2)
  );

  // The debug port observes committed state only, so it never forwards.
  reg_file_rport #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .BYPASS(1'b0)) u_rport_dbg (
    .addr     (DA),
    .regs     (regs_view),
    .byp_en   (1'b0),
    .byp_addr (A3),
    .byp_data (WD3),
    .data     (DRD)
  );

endmodule
